// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, NOP word and reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads {pc+4, inst} one edge after fetch when enabled;
// flush loads NOP instead of inst, and a cleared enable holds the stage for a stall.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] inst_i,
  output logic [31:0] dpc4_o,
  output logic [31:0] dinst_o
);

  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] dinst_q, dinst_d;

  always_comb begin
    dpc4_d  = dpc4_q;
    dinst_d = dinst_q;
    if (en_i) begin
      dpc4_d  = pc4_i;
      dinst_d = flush_i ? NOP : inst_i;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dpc4_q  <= 32'h0000_0000;
      dinst_q <= NOP;
    end else begin
      dpc4_q  <= dpc4_d;
      dinst_q <= dinst_d;
    end
  end

  assign dpc4_o  = dpc4_q;
  assign dinst_o = dinst_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, next-PC select, IF/ID capture and fetch/stall counters.
// Fetched word reaches dinst one edge after pc; stall holds PC and IF/ID, flush overrides stall.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        advance;

  assign pc4     = pc_q + WORD_BYTES;
  assign advance = flush | ~stall;

  // Low address bits are dropped so a misaligned target can never reach the PC.
  always_comb begin
    npc = pc4;
    case (pcsrc_e'(pcsrc))
      PC_SEQ:  npc = pc4;
      PC_BR:   npc = bpc;
      PC_JR:   npc = rpc;
      PC_J:    npc = jpc;
      default: npc = pc4;
    endcase
    npc = word_align(npc);
  end

  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      pc_d = npc;
    end else if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      pc_d        = npc;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  if_id_reg #(
    .NOP (NOP)
  ) u_if_id (
    .clk     (clk),
    .clrn    (clrn),
    .en_i    (advance),
    .flush_i (flush),
    .pc4_i   (pc4),
    .inst_i  (inst),
    .dpc4_o  (dpc4),
    .dinst_o (dinst)
  );

  assign pc        = pc_q;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected state per cycle,
// each scenario task pops and compares after the edge, plus fixed program values.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } obs_t;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic        flush;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc, inst;
  logic [31:0] pc, dpc4, dinst, fetch_cnt, stall_cnt;

  int   n_total = 0;
  int   n_pass  = 0;
  obs_t sb[$];
  obs_t exp_o;
  obs_t rst_o;

  logic [31:0] m_pc, m_dinst, m_dpc4, m_fc, m_sc;

  fetch_stage dut (
    .clk       (clk),
    .clrn      (clrn),
    .stall     (stall),
    .flush     (flush),
    .pcsrc     (pcsrc),
    .bpc       (bpc),
    .rpc       (rpc),
    .jpc       (jpc),
    .inst      (inst),
    .pc        (pc),
    .dpc4      (dpc4),
    .dinst     (dinst),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h3404_0050;
      32'h04:  return 32'h8c85_0000;
      32'h08:  return 32'h2084_0004;
      32'h0C:  return 32'h8c89_0000;
      32'h10:  return 32'h0109_4020;
      32'h14:  return 32'h20a5_ffff;
      32'h18:  return 32'hac88_0000;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb inst = im_word(pc);

  function automatic obs_t observe();
    return '{pc: pc, dinst: dinst, dpc4: dpc4, fcnt: fetch_cnt, scnt: stall_cnt};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_dinst = 32'h0; m_dpc4 = 32'h0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  // Drive one cycle of inputs, advance the reference model, queue its expected state.
  task automatic cyc(input logic st, input logic fl, input logic [1:0] src,
                     input logic [31:0] b, input logic [31:0] r, input logic [31:0] j);
    logic [31:0] tgt;
    logic [31:0] p4;
    stall = st; flush = fl; pcsrc = src; bpc = b; rpc = r; jpc = j;
    p4  = m_pc + 32'd4;
    tgt = (src == 2'b01) ? b : (src == 2'b10) ? r : (src == 2'b11) ? j : p4;
    tgt[1:0] = 2'b00;
    if (fl) begin
      m_dinst = 32'h0; m_dpc4 = p4; m_pc = tgt;
    end else if (st) begin
      m_sc = m_sc + 32'd1;
    end else begin
      m_dinst = im_word(m_pc); m_dpc4 = p4; m_pc = tgt; m_fc = m_fc + 32'd1;
    end
    sb.push_back('{pc: m_pc, dinst: m_dinst, dpc4: m_dpc4, fcnt: m_fc, scnt: m_sc});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_o = '0;
    clrn = 1'b0; stall = 1'b0; flush = 1'b0; pcsrc = 2'b00;
    bpc = '0; rpc = '0; jpc = '0;
    model_reset();
    #2;
    n_total++;
    if (observe() !== rst_o) $display("FAIL reset_state: got %h want %h", observe(), rst_o);
    else n_pass++;
    @(posedge clk); #2;
    clrn = 1'b1;
    n_total++;
    if (pc !== 32'h0 || dinst !== 32'h0) $display("FAIL reset_release: got pc=%h dinst=%h want 0/0", pc, dinst);
    else n_pass++;
  endtask

  task automatic test_seq_fetch();
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 2'b00, '0, '0, '0);
      exp_o = sb.pop_front();
      n_total++;
      if (observe() !== exp_o) $display("FAIL seq_edge%0d: got %h want %h", i, observe(), exp_o);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if (pc !== 32'h4 || dinst !== 32'h3404_0050 || dpc4 !== 32'h4)
          $display("FAIL seq_first: got pc=%h dinst=%h dpc4=%h want 4/34040050/4", pc, dinst, dpc4);
        else n_pass++;
      end
    end
    n_total++;
    if (pc !== 32'h10 || dinst !== 32'h8c89_0000)
      $display("FAIL seq_fourth: got pc=%h dinst=%h want 10/8c890000", pc, dinst);
    else n_pass++;
  endtask

  task automatic test_load_use_stall();
    cyc(1'b1, 1'b0, 2'b01, 32'h80, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h10 || dinst !== 32'h8c89_0000 || stall_cnt !== 32'd1)
      $display("FAIL stall_hold: got %h want %h", observe(), exp_o);
    else n_pass++;
    cyc(1'b0, 1'b0, 2'b00, '0, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || dinst !== 32'h0109_4020 || fetch_cnt !== 32'd5)
      $display("FAIL stall_resume: got %h want %h", observe(), exp_o);
    else n_pass++;
  endtask

  task automatic test_redirect();
    cyc(1'b0, 1'b0, 2'b11, '0, '0, 32'h08);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h08) $display("FAIL jump_to_8: got %h want %h", observe(), exp_o);
    else n_pass++;
    cyc(1'b0, 1'b0, 2'b01, 32'h40, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h40 || dinst !== 32'h2084_0004 || dpc4 !== 32'h0C)
      $display("FAIL branch: got %h want %h", observe(), exp_o);
    else n_pass++;
    cyc(1'b0, 1'b0, 2'b01, 32'h43, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h40) $display("FAIL branch_align: got %h want %h", observe(), exp_o);
    else n_pass++;
    cyc(1'b0, 1'b0, 2'b10, '0, 32'h22, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h20) $display("FAIL jr_align: got %h want %h", observe(), exp_o);
    else n_pass++;
  endtask

  task automatic test_flush_during_stall();
    logic [31:0] fc0, sc0;
    fc0 = fetch_cnt; sc0 = stall_cnt;
    cyc(1'b1, 1'b1, 2'b11, '0, '0, 32'h100);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h100 || dinst !== 32'h0 || fetch_cnt !== fc0 || stall_cnt !== sc0)
      $display("FAIL flush_stall: got %h want %h", observe(), exp_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    cyc(1'b0, 1'b0, 2'b11, '0, '0, 32'hFFFF_FFFC);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want %h", observe(), exp_o);
    else n_pass++;
    cyc(1'b0, 1'b0, 2'b00, '0, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h0 || dpc4 !== 32'h0) $display("FAIL pc_wrap: got %h want %h", observe(), exp_o);
    else n_pass++;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    m_fc = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 2'b00, '0, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || fetch_cnt !== 32'h0) $display("FAIL fetch_cnt_wrap: got %h want %h", observe(), exp_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    time t0;
    cyc(1'b1, 1'b0, 2'b00, '0, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o) $display("FAIL pre_reset_stall: got %h want %h", observe(), exp_o);
    else n_pass++;
    #2;
    t0 = $time;
    clrn = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (observe() !== rst_o || ($time - t0) >= 5)
      $display("FAIL async_reset: got %h want %h", observe(), rst_o);
    else n_pass++;
    #1;
    clrn = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, '0, '0, '0);
    exp_o = sb.pop_front();
    n_total++;
    if (observe() !== exp_o || pc !== 32'h4 || dinst !== 32'h3404_0050)
      $display("FAIL post_reset_fetch: got %h want %h", observe(), exp_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_load_use_stall();
    test_redirect();
    test_flush_during_stall();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, %0d checks done", n_total);
    $fatal(1);
  end

endmodule
